param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
Parametrised multi-port register file for the datapath, generalising the 16x8 single-write register file.
- Configurable data width, depth and number of read ports.
- Two write ports with fixed priority.
- Same-cycle write-to-read bypass.
- Sequential bulk-clear engine.
Sits between decode (addresses) and ALU/writeback (data).

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent combinational read ports (1..4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en0  in  1  write enable, port 0
wr_addr0  in  ADDR_W  write address, port 0
wr_data0  in  DATA_W  write data, port 0
wr_en1  in  1  write enable, port 1 (higher priority)
wr_addr1  in  ADDR_W  write address, port 1
wr_data1  in  DATA_W  write data, port 1
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
clr_req  in  1  single-cycle pulse requesting bulk clear
clr_busy  out  1  high while a bulk clear is in progress

Behaviour:
- Reset: asserting reset takes effect immediately, asynchronous to clk.
  - All DEPTH registers go to 0.
  - FSM goes to IDLE; clear counter goes to 0; clr_busy = 0.
  - rd_data = 0 on all ports.
- Writes (IDLE only), committed on the rising edge:
  - Each enabled port writes its data to its address.
  - wr_en0 and wr_en1 both set with wr_addr0 == wr_addr1: port 1 data is stored; port 0 is dropped.
  - Different addresses: both are written in the same cycle.
- Reads: purely combinational, zero latency.
  - rd_data[k] = mem[rd_addr[k]].
  - Bypass (IDLE only): rd_addr[k] matching an enabled write address returns that write data in the same cycle.
  - Port 1 match beats port 0 match.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on a clk edge with clr_req = 1; counter = 0.
  - In CLEAR, each edge writes 0 to mem[counter], then counter increments.
  - After clearing DEPTH-1: CLEAR -> IDLE and counter = 0.
  - clr_busy = 1 exactly while in CLEAR: DEPTH cycles, registered output, asserted the cycle after clr_req.
  - clr_req while in CLEAR is ignored; the clear is not restarted.
  - wr_en0/wr_en1 are dropped (no write, no bypass) while in CLEAR.
  - Reads in CLEAR return current array contents: partially cleared, no bypass.
  - Write and clr_req in the same IDLE cycle: the write commits on that edge, then CLEAR starts, so it is later cleared.
  - Reset mid-clear aborts to IDLE with all registers 0.
- Widths: counter is ADDR_W+1 bits or terminates on compare with DEPTH-1. No arithmetic on data.

Optional Feature:
PARAM_REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are discarded on both ports.
  - Reads of address 0 return 0, including when a write to 0 is in flight; no bypass for address 0.
- Undefined: address 0 is an ordinary register.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} clr_state_t
  - default width/depth localparams
  - a DEPTH helper function
- Natural sub-module: regfile_clear_fsm (state, counter, clr_busy; outputs clr_we/clr_addr to the array).
- Array, write priority and bypass stay in the top module.

Test Plan:
- Reset, then read all addresses on both ports -> all 0; clr_busy = 0.
- Conflicting write: port0 (addr 3, 0x11) and port1 (addr 3, 0x22) in the same cycle -> next cycle mem[3] = 0x22. Same cycle, rd_addr0 = 3 -> bypass returns 0x22.
- Split write: port0 (addr 5, 0xA5), port1 (addr 9, 0x5A) -> both readable next cycle; rd ports 0/1 at 5/9 return 0xA5/0x5A.
- Fill all 16 regs with 0xFF, pulse clr_req:
  - clr_busy high for exactly 16 cycles.
  - Write to addr 7 during CLEAR is ignored.
  - Afterwards all regs = 0.
  - Second clr_req mid-clear does not extend busy.
- Assert reset asynchronously mid-clear (counter = 6) -> clr_busy drops immediately; all reads 0.
- With PARAM_REGFILE_ZERO_REG_EN defined: write 0x77 to addr 0 -> reads (same cycle and next) return 0. Without the macro -> next-cycle read returns 0x77.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
package regfile_pkg;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NUM_RD = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks every address once, one per clock,
// driving a zero-write strobe into the register array.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // clr_req is deliberately ignored here: a clear is never restarted
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/param_register_file.sv
// Multi-read, dual-write register file with same-cycle bypass and bulk clear.
// Define PARAM_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = depth_of(ADDR_W);

`ifdef PARAM_REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we0_ok, we1_ok;

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Qualified enables gate both the array write and the bypass path
    assign we0_ok = wr_en0 && !clr_busy && !(ZERO_REG && (wr_addr0 == '0));
    assign we1_ok = wr_en1 && !clr_busy && !(ZERO_REG && (wr_addr1 == '0));

    // Port 1 is assigned last so it wins an address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (we0_ok) mem_q[wr_addr0] <= wr_data0;
            if (we1_ok) mem_q[wr_addr1] <= wr_data1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdv = mem_q[ra];
            if (we0_ok && (wr_addr0 == ra)) rdv = wr_data0;
            if (we1_ok && (wr_addr1 == ra)) rdv = wr_data1;
            if (reset) rdv = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdv;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed bench for param_register_file against an array model.
module tb_param_register_file;

`ifdef PARAM_REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en0, wr_en1;
    logic [3:0]  wr_addr0, wr_addr1;
    logic [7:0]  wr_data0, wr_data1;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        clr_req;
    logic        clr_busy;

    int tests  = 0;
    int errors = 0;

    // reference model
    int m_mem [16];
    bit m_busy;
    int m_idx;
    bit last_busy;

    param_register_file #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en0   (wr_en0),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_en1   (wr_en1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_rd(input int a);
        int v;
        v = m_mem[a];
        if (!m_busy) begin
            if (wr_en0 && int'(wr_addr0) == a) v = wr_data0;
            if (wr_en1 && int'(wr_addr1) == a) v = wr_data1;
            if (ZERO && a == 0) v = 0;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // One clock: drive at negedge, check reads/busy, then advance the model
    task automatic cyc(input bit e0, input int a0, input int d0,
                       input bit e1, input int a1, input int d1,
                       input int r0, input int r1, input bit clr,
                       input int x0 = -1, input int x1 = -1);
        @(negedge clk);
        wr_en0 = e0; wr_addr0 = a0[3:0]; wr_data0 = d0[7:0];
        wr_en1 = e1; wr_addr1 = a1[3:0]; wr_data1 = d1[7:0];
        rd_addr = {r1[3:0], r0[3:0]};
        clr_req = clr;
        #1;
        last_busy = clr_busy;
        chk("busy", clr_busy, m_busy);
        chk($sformatf("rd0@%0d", r0), rd_data[7:0], exp_rd(r0));
        chk($sformatf("rd1@%0d", r1), rd_data[15:8], exp_rd(r1));
        if (x0 >= 0) chk($sformatf("dir_rd0@%0d", r0), rd_data[7:0], x0);
        if (x1 >= 0) chk($sformatf("dir_rd1@%0d", r1), rd_data[15:8], x1);
        @(posedge clk);
        if (m_busy) begin
            m_mem[m_idx] = 0;
            m_idx++;
            if (m_idx == 16) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end
        end else begin
            if (e0 && !(ZERO && a0 == 0)) m_mem[a0] = d0;
            if (e1 && !(ZERO && a1 == 0)) m_mem[a1] = d1;
            if (clr) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b1;
        wr_en0 = 0; wr_en1 = 0; wr_addr0 = 0; wr_addr1 = 0;
        wr_data0 = 0; wr_data1 = 0; rd_addr = 0; clr_req = 0;
        model_reset();
        #1;
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_rd", rd_data, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 16; a += 2) cyc(0, 0, 0, 0, 0, 0, a, a + 1, 0, 0, 0);

        // conflicting write, port 1 wins; same-cycle bypass
        cyc(1, 3, 8'h11, 1, 3, 8'h22, 3, 3, 0, 8'h22, 8'h22);
        cyc(0, 0, 0, 0, 0, 0, 3, 4, 0, 8'h22, 0);

        // split write
        cyc(1, 5, 8'hA5, 1, 9, 8'h5A, 5, 9, 0, 8'hA5, 8'h5A);
        cyc(0, 0, 0, 0, 0, 0, 5, 9, 0, 8'hA5, 8'h5A);

        // address 0 behaviour
        cyc(1, 0, 8'h77, 0, 0, 0, 0, 0, 0, ZERO ? 0 : 8'h77, ZERO ? 0 : 8'h77);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO ? 0 : 8'h77);

        // random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
                $urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 24) == 0));
        end
        // drain any clear still running
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 0, i % 16, 15 - (i % 16), 0);

        // fill, clear, write and re-request during clear
        for (int i = 0; i < 8; i++) cyc(1, 2 * i, 8'hFF, 1, 2 * i + 1, 8'hFF, 2 * i, 2 * i + 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 7, 8, 1, 8'hFF, 8'hFF);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(i == 3, 7, 8'h3C, 0, 0, 0, 7, 15, i == 5);
            if (last_busy) busy_cnt++;
        end
        chk("busy_len", busy_cnt, 16);
        for (int a = 0; a < 16; a += 2) cyc(0, 0, 0, 0, 0, 0, a, a + 1, 0, 0, 0);

        // asynchronous reset in the middle of a clear
        for (int i = 0; i < 8; i++) cyc(1, 2 * i, 8'hFF, 1, 2 * i + 1, 8'hFF, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 8, 9, 1, 8'hFF, 8'hFF);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 8, 9, 0, 8'hFF, 8'hFF);
        chk("mid_idx", m_idx, 6);
        @(negedge clk);
        rd_addr = 8'h98;
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", clr_busy, 1'b0);
        chk("async_rd", rd_data, 16'h0);
        model_reset();
        for (int a = 0; a < 16; a += 2) begin
            rd_addr = {4'(a + 1), 4'(a)};
            #1;
            chk($sformatf("rst_rd@%0d", a), rd_data, 16'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 16; a += 2) cyc(0, 0, 0, 0, 0, 0, a, a + 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
